ahb_sram_slave: RTL
===================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 32, HADDR width.
REQ-002 Parameter DATA_W, default 32, HWDATA/HRDATA width; only 32 supported.
REQ-003 Parameter MEM_WORDS, default 256, number of 32-bit storage words; power of two.
REQ-004 Parameter WAIT_STATES, default 0, range 0-7; wait cycles inserted before each OKAY data phase completes.
REQ-005 Ports: HCLK  in  1  sole clock, all logic on rising edge.
REQ-006 HRESET  in  1  reset, synchronous, active-high.
REQ-007 HSEL  in  1  slave select.
REQ-008 HADDR  in  ADDR_W  byte address.
REQ-009 HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 HWRITE  in  1  1=write.
REQ-011 HSIZE  in  3  0=byte, 1=half, 2=word; others illegal.
REQ-012 HWDATA  in  32  write data, valid in data phase.
REQ-013 HREADY  in  1  bus-wide ready; address phase sampled only when 1.
REQ-014 HRDATA  out  32  read data.
REQ-015 HREADYOUT  out  1  slave ready.
REQ-016 HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-017 Address phase accepted when HSEL & HREADY & HTRANS[1] at a rising edge; HADDR, HWRITE, HSIZE registered into data-phase regs.
REQ-018 IDLE/BUSY, or HSEL=0, with HREADY=1: no transfer; next cycle HREADYOUT=1, HRESP=OKAY.
REQ-019 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-020 IDLE: HREADYOUT=1, HRESP=0; valid accepted transfer -> WAIT if WAIT_STATES>0, else DATA; illegal -> ERR1.
REQ-021 Illegal = word index >= MEM_WORDS, HSIZE>2, or misaligned (half with HADDR[0]=1; word with HADDR[1:0]!=0).
REQ-022 WAIT: HREADYOUT=0, HRESP=0; wait counter loaded with WAIT_STATES at acceptance, decrements per cycle; at 1 -> DATA.
REQ-023 DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle; a new accepted transfer in the same cycle follows REQ-020 transitions, else -> IDLE.
REQ-024 ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
REQ-025 ERR2: HREADYOUT=1, HRESP=1; new address phase accepted per REQ-020, else -> IDLE.
REQ-026 Write: at the edge ending the DATA cycle, byte lanes selected by HSIZE/HADDR[1:0] from HWDATA (little-endian) written; other lanes untouched.
REQ-027 Read: HRDATA = full addressed word during DATA; all lanes driven, master picks lanes.
REQ-028 HRDATA = 0 outside DATA cycles.
REQ-029 Read immediately after write to same word returns newly written data, no extra stall (write commits at the edge read data phase starts).
REQ-030 Errored transfers never modify memory.
REQ-031 HTRANS changes during WAIT ignored (spec-legal only IDLE->NONSEQ); pipelined next address sampled only when HREADY=1.

Reset
REQ-032 HRESET=1 at an edge: FSM->IDLE, wait counter 0, data-phase regs cleared; HREADYOUT=1, HRESP=0, HRDATA=0 next cycle.
REQ-033 Reset mid-transfer (WAIT/ERR1) aborts it with no memory write.
REQ-034 Memory contents not reset.

Structure
REQ-035 ahb_pkg holds HTRANS/HSIZE enums, HRESP constants, FSM state typedef.
REQ-036 Storage in one sub-module ahb_sram_bytemem: MEM_WORDS x 32, 4 byte-write-enables, combinational read port.

Verification
REQ-037 WAIT_STATES=0: NONSEQ word write 0x10=0xDEADBEEF, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 every cycle, HRESP=0.
REQ-038 Byte write 0x11=0xAA over 0x00000000, then word read 0x10 -> 0x0000AA00.
REQ-039 WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then high with data.
REQ-040 Read 0x400 with MEM_WORDS=256 -> HREADYOUT 0/1 with HRESP 1/1 over two cycles, memory unchanged.
REQ-041 Back-to-back write 0x20=0x1234 then read 0x20 pipelined -> read returns 0x00001234, no stall.
REQ-042 HRESET asserted in WAIT of a write -> next cycle HREADYOUT=1, HRESP=0, target word unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and lane/alignment helpers for the
// SRAM slave and its storage.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] m;
        m = '0;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << offs;
            HSIZE_HALF: m = offs[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = '0;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offs);
        return ((size == HSIZE_HALF) && offs[0]) || ((size == HSIZE_WORD) && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite slave-side bus bundle. Handshake: an address phase is taken at a
// rising edge when HSEL & HREADY & HTRANS[1]; a data phase ends at the edge where HREADYOUT=1.
interface ahb_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_bytemem.sv
// Word-organised SRAM with per-byte write enables and a combinational read
// port, so a word written at an edge is visible immediately after it.
module ahb_sram_bytemem #(
    parameter  int MEM_WORDS = 256,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[waddr][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: optional wait states, two-cycle ERROR response for
// out-of-range, oversized or misaligned transfers, byte-lane writes.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_sram_slave_if.slave     bus,
    output state_e              dbg_state
);

    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    state_e           state_q, state_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       offs_q, offs_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;

    logic             accept;
    logic             out_of_range;
    logic             illegal;
    logic [3:0]       mem_we;
    logic [31:0]      mem_rdata;
    logic             unused_htrans_lsb;

    assign unused_htrans_lsb = bus.HTRANS[0];

    // Only states that present HREADYOUT=1 may take a new address phase, so a
    // stray HTRANS during WAIT/ERR1 is ignored even if HREADY misbehaves.
    assign accept       = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_q;
    assign out_of_range = |bus.HADDR[ADDR_W-1:IDX_W+2];
    assign illegal      = out_of_range | (bus.HSIZE > 3'd2) |
                          is_misaligned(bus.HSIZE, bus.HADDR[1:0]);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        offs_d     = offs_q;
        write_d    = write_q;
        size_d     = size_q;

        case (state_q)
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q <= 3'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                if (accept) begin
                    idx_d   = bus.HADDR[IDX_W+1:2];
                    offs_d  = bus.HADDR[1:0];
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            offs_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            offs_q      <= offs_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Write commits at the edge closing the DATA cycle; a reset on that edge wins.
    assign mem_we = ((state_q == ST_DATA) && write_q && !HRESET) ? lane_mask(size_q, offs_q) : 4'b0000;

    ahb_sram_bytemem #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (bus.HWDATA),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    assign bus.HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign dbg_state     = state_q;

endmodule
